// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM result, aligns and extends loads,
// and shares the register-file write port with a buffered long-latency unit.
module wb_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_mem_to_reg,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic [1:0]        mem_load_size,
    input  logic              mem_load_unsigned,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              stall_req,
    output logic              regWrite,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0] hold_rd_q, hold_rd_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [1:0]        off;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              ext_bit;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] p_data;
    logic              p_valid;
    logic              drain;
    logic              lu_take;

    assign lu_ready  = ~hold_valid_q & ~rst;
    assign stall_req = hold_valid_q & (cnt_q == STARVE_LIM);

    assign regWrite   = reg_write_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;

    always_comb begin
        off      = mem_alu_result[1:0];
        byte_sel = mem_load_data[{off, 3'b000} +: 8];
        half_sel = off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
        ext_bit  = 1'b0;
        load_val = mem_load_data;
        unique case (mem_load_size)
            2'b00: begin
                ext_bit  = ~mem_load_unsigned & byte_sel[7];
                load_val = {{(DATA_W-8){ext_bit}}, byte_sel};
            end
            2'b01: begin
                ext_bit  = ~mem_load_unsigned & half_sel[15];
                load_val = {{(DATA_W-16){ext_bit}}, half_sel};
            end
            default: load_val = mem_load_data;
        endcase
        p_data = mem_mem_to_reg ? load_val : mem_alu_result;
    end

    assign p_valid = ~stall & ~flush & ~stall_req & mem_valid
                   & mem_reg_write & (mem_rd != '0);

    // lu_rd == 0 is consumed but never buffered, so r0 is never written
    assign lu_take = lu_valid & lu_ready & (lu_rd != '0);

    always_comb begin
        reg_write_d  = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        drain        = 1'b0;
        if (stall_req) begin
            drain = 1'b1;
        end else if (p_valid) begin
            reg_write_d  = 1'b1;
            write_addr_d = mem_rd;
            write_data_d = p_data;
        end else if (hold_valid_q) begin
            drain = 1'b1;
        end
        if (drain) begin
            reg_write_d  = 1'b1;
            write_addr_d = hold_rd_q;
            write_data_d = hold_data_q;
            hold_valid_d = 1'b0;
        end
        if (lu_take) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = lu_rd;
            hold_data_d  = lu_data;
        end
        if (hold_valid_q && !drain) begin
            cnt_d = (cnt_q == STARVE_LIM) ? cnt_q : cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            cnt_q        <= 4'd0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
